guess_round_sequencer: RTL and testbench

- Game-flow controller for the 4-digit number-guessing datapath (1A2B style). Consumes debounced keypad codes and assembles the secret and guess digit vectors. Issues a request/done handshake to the A/B match unit and tracks attempts.
- Sits between the keypad scanner and the match/seven-segment blocks, replacing free-running mode-switch sequencing with an explicit round FSM.

---
 rtl/guess_round_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_guess_round_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/guess_round_sequencer.sv
// guess_round_sequencer: round FSM for the 4-digit 1A2B guessing game.
// Assembles the secret and guess digit vectors from debounced keypad codes.
// Runs a request/done handshake with the A/B match unit and counts attempts.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   key_valid/code   - one-cycle key strobe and code (0-9, A bksp, E enter, F new game)
//   match_done,r_a,b - match unit result handshake
//   secret, guess    - digit vectors, digit0 in [15:12]
//   entry_count      - digits in the current entry
//   match_req        - request to match unit
//   tries, last_a/b  - attempt count and most recent result
//   win, lose, err   - round outcome flags and rejected-key pulse
//   state_code       - 0 SET_SECRET, 1 GUESS, 2 CHECK, 3 WIN, 4 LOSE
module guess_round_sequencer #(
  parameter int unsigned MAX_TRIES    = 10,
  parameter bit          ALLOW_REPEAT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        match_done,
  input  logic [2:0]  r_a,
  input  logic [2:0]  r_b,
  output logic [15:0] secret,
  output logic [15:0] guess,
  output logic [2:0]  entry_count,
  output logic        match_req,
  output logic [3:0]  tries,
  output logic [2:0]  last_a,
  output logic [2:0]  last_b,
  output logic        win,
  output logic        lose,
  output logic        err,
  output logic [2:0]  state_code
);

  localparam int unsigned DIGITS = 4;

  typedef enum logic [2:0] {
    SET_SECRET = 3'd0,
    GUESS      = 3'd1,
    CHECK      = 3'd2,
    WIN        = 3'd3,
    LOSE       = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [15:0] secret_n, guess_n, entry, entry_n;
  logic [2:0]  entry_count_n, last_a_n, last_b_n;
  logic [3:0]  tries_n, tries_inc;
  logic        match_req_n, err_n, dup;

  // Vector currently being edited by the keypad
  assign entry     = (state == SET_SECRET) ? secret : guess;
  assign tries_inc = (tries == 4'hF) ? tries : tries + 4'd1;

  // Digit already present among the entered positions
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (3'(i) < entry_count && entry[4*(DIGITS-1-i) +: 4] == key_code)
        dup = 1'b1;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    state_n       = state;
    secret_n      = secret;
    guess_n       = guess;
    entry_n       = entry;
    entry_count_n = entry_count;
    tries_n       = tries;
    last_a_n      = last_a;
    last_b_n      = last_b;
    match_req_n   = match_req;
    err_n         = 1'b0;

    unique case (state)
      SET_SECRET, GUESS: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (entry_count == 3'(DIGITS) || (dup && !ALLOW_REPEAT)) begin
              err_n = 1'b1;
            end else begin
              for (int i = 0; i < DIGITS; i++)
                if (3'(i) == entry_count) entry_n[4*(DIGITS-1-i) +: 4] = key_code;
              entry_count_n = entry_count + 3'd1;
            end
          end else if (key_code == 4'hA) begin
            if (entry_count == 3'd0) begin
              err_n = 1'b1;
            end else begin
              for (int i = 0; i < DIGITS; i++)
                if (3'(i) == entry_count - 3'd1) entry_n[4*(DIGITS-1-i) +: 4] = 4'h0;
              entry_count_n = entry_count - 3'd1;
            end
          end else if (key_code == 4'hE) begin
            if (entry_count != 3'(DIGITS)) begin
              err_n = 1'b1;
            end else if (state == SET_SECRET) begin
              state_n       = GUESS;
              guess_n       = 16'h0;
              entry_count_n = 3'd0;
              tries_n       = 4'd0;
            end else begin
              state_n     = CHECK;
              match_req_n = 1'b1;
            end
          end
          // B/C/D fall through with no effect; F handled below
        end
        // Write back the edited vector before any clear on enter/new game
        if (state == SET_SECRET) secret_n = entry_n;
        else if (state_n == GUESS) guess_n = entry_n;
        else if (state_n == CHECK) guess_n = entry_n;
        if (state == SET_SECRET && state_n == GUESS) guess_n = 16'h0;
      end
      CHECK: begin
        // Keys are ignored here; a simultaneous key is simply dropped
        if (match_done) begin
          last_a_n    = r_a;
          last_b_n    = r_b;
          tries_n     = tries_inc;
          match_req_n = 1'b0;
          if (r_a == 3'd4) begin
            state_n = WIN;
          end else if (tries_inc == 4'(MAX_TRIES)) begin
            state_n = LOSE;
          end else begin
            state_n       = GUESS;
            guess_n       = 16'h0;
            entry_count_n = 3'd0;
          end
        end
      end
      default: ;
    endcase

    // New game from any state except CHECK
    if (key_valid && key_code == 4'hF && state != CHECK) begin
      state_n       = SET_SECRET;
      secret_n      = 16'h0;
      guess_n       = 16'h0;
      entry_count_n = 3'd0;
      tries_n       = 4'd0;
      last_a_n      = 3'd0;
      last_b_n      = 3'd0;
      match_req_n   = 1'b0;
      err_n         = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SET_SECRET;
      secret      <= 16'h0;
      guess       <= 16'h0;
      entry_count <= 3'd0;
      tries       <= 4'd0;
      last_a      <= 3'd0;
      last_b      <= 3'd0;
      match_req   <= 1'b0;
      err         <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state       <= state_n;
      secret      <= secret_n;
      guess       <= guess_n;
      entry_count <= entry_count_n;
      tries       <= tries_n;
      last_a      <= last_a_n;
      last_b      <= last_b_n;
      match_req   <= match_req_n;
      err         <= err_n;
      win         <= (state_n == WIN);
      lose        <= (state_n == LOSE);
    end
  end

  assign state_code = 3'(state);

endmodule

// File: tb/tb_guess_round_sequencer.sv
// Directed bench for guess_round_sequencer (MAX_TRIES=2, no repeats).
module tb_guess_round_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        match_done;
  logic [2:0]  r_a, r_b;
  logic [15:0] secret, guess;
  logic [2:0]  entry_count;
  logic        match_req;
  logic [3:0]  tries;
  logic [2:0]  last_a, last_b;
  logic        win, lose, err;
  logic [2:0]  state_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  guess_round_sequencer #(.MAX_TRIES(2), .ALLOW_REPEAT(1'b0)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .match_done(match_done), .r_a(r_a), .r_b(r_b),
    .secret(secret), .guess(guess), .entry_count(entry_count),
    .match_req(match_req), .tries(tries), .last_a(last_a), .last_b(last_b),
    .win(win), .lose(lose), .err(err), .state_code(state_code)
  );

  // One key strobe; returns at the following negedge with outputs settled
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic type4(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
  endtask

  // One-cycle match_done with given result
  task automatic answer(input logic [2:0] a, input logic [2:0] b);
    match_done = 1'b1;
    r_a = a;
    r_b = b;
    @(negedge clk);
    match_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (state_code !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_code); end
    checks++; if ({secret, guess} !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0", secret, guess); end
    checks++; if ({entry_count, tries, last_a, last_b} !== 13'h0) begin errors++; $display("FAIL reset_counts got=%0d/%0d/%0d/%0d exp=0", entry_count, tries, last_a, last_b); end
    checks++; if ({match_req, win, lose, err} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {match_req, win, lose, err}); end
  endtask

  task automatic test_entry_errors;
    press(4'd5);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL first5_err got=%b exp=0", err); end
    press(4'd5);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL dup_err got=%b exp=1", err); end
    checks++; if (entry_count !== 3'd1 || secret !== 16'h5000) begin errors++; $display("FAIL dup_entry got=%0d/%h exp=1/5000", entry_count, secret); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", err); end
    press(4'hA);
    checks++; if (entry_count !== 3'd0 || secret !== 16'h0 || err !== 1'b0) begin errors++; $display("FAIL bksp got=%0d/%h/%b exp=0/0000/0", entry_count, secret, err); end
    press(4'hA);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bksp_empty_err got=%b exp=1", err); end
    press(4'hB);
    checks++; if (err !== 1'b0 || entry_count !== 3'd0) begin errors++; $display("FAIL key_b_ignored got=%b/%0d exp=0/0", err, entry_count); end
  endtask

  task automatic test_set_secret;
    type4(16'h1234);
    press(4'd5);
    checks++; if (err !== 1'b1 || secret !== 16'h1234 || entry_count !== 3'd4) begin errors++; $display("FAIL fifth_digit got=%b/%h/%0d exp=1/1234/4", err, secret, entry_count); end
    press(4'hE);
    checks++; if (state_code !== 3'd1 || secret !== 16'h1234 || tries !== 4'd0 || entry_count !== 3'd0) begin errors++; $display("FAIL secret_enter got=%0d/%h/%0d/%0d exp=1/1234/0/0", state_code, secret, tries, entry_count); end
  endtask

  task automatic test_check_miss;
    type4(16'h1329);
    press(4'hE);
    checks++; if (state_code !== 3'd2 || match_req !== 1'b1 || guess !== 16'h1329) begin errors++; $display("FAIL enter_check got=%0d/%b/%h exp=2/1/1329", state_code, match_req, guess); end
    press(4'hF);
    checks++; if (state_code !== 3'd2 || err !== 1'b0 || secret !== 16'h1234) begin errors++; $display("FAIL f_in_check got=%0d/%b/%h exp=2/0/1234", state_code, err, secret); end
    @(negedge clk);
    checks++; if (match_req !== 1'b1) begin errors++; $display("FAIL req_held got=%b exp=1", match_req); end
    // key arriving with done is dropped
    key_valid = 1'b1;
    key_code  = 4'd7;
    answer(3'd1, 3'd2);
    key_valid = 1'b0;
    checks++; if (last_a !== 3'd1 || last_b !== 3'd2 || tries !== 4'd1) begin errors++; $display("FAIL miss_result got=%0d/%0d/%0d exp=1/2/1", last_a, last_b, tries); end
    checks++; if (state_code !== 3'd1 || guess !== 16'h0 || entry_count !== 3'd0 || match_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL miss_return got=%0d/%h/%0d/%b/%b exp=1/0000/0/0/0", state_code, guess, entry_count, match_req, err); end
  endtask

  task automatic test_win;
    type4(16'h1234);
    press(4'hE);
    repeat (2) @(negedge clk);
    answer(3'd4, 3'd0);
    // tries reaches MAX_TRIES here but r_a==4 takes priority
    checks++; if (win !== 1'b1 || lose !== 1'b0 || state_code !== 3'd3 || tries !== 4'd2) begin errors++; $display("FAIL win got=%b/%b/%0d/%0d exp=1/0/3/2", win, lose, state_code, tries); end
    press(4'd5);
    checks++; if (guess !== 16'h1234 || err !== 1'b0 || win !== 1'b1) begin errors++; $display("FAIL win_hold got=%h/%b/%b exp=1234/0/1", guess, err, win); end
    press(4'hF);
    checks++; if (state_code !== 3'd0 || {secret, guess} !== 32'h0 || {tries, last_a, last_b, entry_count} !== 13'h0 || win !== 1'b0) begin errors++; $display("FAIL win_newgame got=%0d/%h/%h/%0d/%0d exp=0/0/0/0/0", state_code, secret, guess, tries, last_a); end
  endtask

  task automatic test_lose;
    type4(16'h1234);
    press(4'hE);
    type4(16'h5678);
    press(4'hE);
    answer(3'd0, 3'd0);
    checks++; if (state_code !== 3'd1 || tries !== 4'd1 || lose !== 1'b0) begin errors++; $display("FAIL lose_first got=%0d/%0d/%b exp=1/1/0", state_code, tries, lose); end
    type4(16'h5679);
    press(4'hE);
    answer(3'd0, 3'd0);
    checks++; if (lose !== 1'b1 || win !== 1'b0 || state_code !== 3'd4 || tries !== 4'd2) begin errors++; $display("FAIL lose got=%b/%b/%0d/%0d exp=1/0/4/2", lose, win, state_code, tries); end
    press(4'hE);
    checks++; if (err !== 1'b0 || lose !== 1'b1) begin errors++; $display("FAIL lose_hold got=%b/%b exp=0/1", err, lose); end
    press(4'hF);
    checks++; if (state_code !== 3'd0 || lose !== 1'b0) begin errors++; $display("FAIL lose_newgame got=%0d/%b exp=0/0", state_code, lose); end
  endtask

  task automatic test_short_enter;
    type4(16'h1234);
    press(4'hE);
    press(4'd1); press(4'd2); press(4'd3);
    press(4'hE);
    checks++; if (err !== 1'b1 || state_code !== 3'd1 || entry_count !== 3'd3) begin errors++; $display("FAIL short_enter got=%b/%0d/%0d exp=1/1/3", err, state_code, entry_count); end
    match_done = 1'b1;
    r_a = 3'd4;
    press(4'd4);
    match_done = 1'b0;
    checks++; if (guess !== 16'h1234 || entry_count !== 3'd4 || state_code !== 3'd1 || tries !== 4'd0 || last_a !== 3'd0) begin errors++; $display("FAIL stray_done got=%h/%0d/%0d/%0d/%0d exp=1234/4/1/0/0", guess, entry_count, state_code, tries, last_a); end
  endtask

  task automatic test_reset_mid_check;
    press(4'hE);
    checks++; if (match_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req got=%b exp=1", match_req); end
    key_valid = 1'b1;
    key_code  = 4'd9;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key_valid = 1'b0;
    checks++; if (match_req !== 1'b0 || state_code !== 3'd0 || secret !== 16'h0 || entry_count !== 3'd0) begin errors++; $display("FAIL reset_mid_check got=%b/%0d/%h/%0d exp=0/0/0000/0", match_req, state_code, secret, entry_count); end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    match_done = 1'b0; r_a = 3'd0; r_b = 3'd0;
    test_reset();
    test_entry_errors();
    test_set_secret();
    test_check_miss();
    test_win();
    test_lose();
    test_short_enter();
    test_reset_mid_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
